// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: drives a req/gnt/rvalid data bus
// for execute-stage accesses, stalls while busy, flags faults.
// Ports: clk_i/rst_i; x_* execute op in; stall_o; dm_* bus;
// m_* results: raw load word, done pulses, exception pulses/address.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic        x_is_load_i,
  input  logic        x_is_store_i,
  input  logic [2:0]  x_funct3_i,
  input  logic [31:0] x_addr_i,
  input  logic [31:0] x_store_data_i,
  output logic        stall_o,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_gnt_i,
  input  logic        dm_rvalid_i,
  input  logic [31:0] dm_rdata_i,
  output logic [31:0] m_dm_dout_o,
  output logic        m_load_done_o,
  output logic        m_store_done_o,
  output logic        m_misalign_o,
  output logic        m_access_fault_o,
  output logic [31:0] m_exc_addr_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          blk_q, blk_d;
  logic          we_q, we_d;
  logic [31:0]   baddr_q, baddr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   dout_q, dout_d;
  logic [31:0]   exc_q, exc_d;
  logic          ld_done_q, ld_done_d;
  logic          st_done_q, st_done_d;
  logic          mis_q, mis_d;
  logic          flt_q, flt_d;

  logic          accept;
  logic          legal;
  logic          misal;
  logic          tmo;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;

  always_comb begin
    legal = 1'b0;
    if (x_is_load_i ^ x_is_store_i) begin
      case (x_funct3_i)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b100, 3'b101:         legal = x_is_load_i;
        default:                legal = 1'b0;
      endcase
    end
  end

  assign misal = ((x_funct3_i[1:0] == 2'b01) & x_addr_i[0])
               | ((x_funct3_i[1:0] == 2'b10) & (|x_addr_i[1:0]));

  always_comb begin
    be_n = 4'b1111;
    wd_n = x_store_data_i;
    unique case (1'b1)
      (x_funct3_i[1:0] == 2'b00): begin
        be_n = 4'b0001 << x_addr_i[1:0];
        wd_n = {4{x_store_data_i[7:0]}};
      end
      (x_funct3_i[1:0] == 2'b01): begin
        be_n = x_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{x_store_data_i[15:0]}};
      end
      default: ;
    endcase
    if (!x_is_store_i) wd_n = '0;
  end

  // blk_q masks the first IDLE cycle after a bus access, while
  // upstream still presents the op that just completed.
  assign accept = x_valid_i & (x_is_load_i | x_is_store_i)
                & (state_q == IDLE) & ~blk_q;
  assign tmo = (state_q != IDLE) & (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = 1'b0;
    we_d      = we_q;
    baddr_d   = baddr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    dout_d    = dout_q;
    exc_d     = exc_q;
    ld_done_d = 1'b0;
    st_done_d = 1'b0;
    mis_d     = 1'b0;
    flt_d     = 1'b0;
    if (tmo) begin
      state_d = IDLE;
      blk_d   = 1'b1;
      flt_d   = 1'b1;
      exc_d   = baddr_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!legal) begin
              flt_d = 1'b1;
              exc_d = x_addr_i;
            end else if (misal) begin
              mis_d = 1'b1;
              exc_d = x_addr_i;
            end else begin
              state_d = REQ;
              cnt_d   = '0;
              we_d    = x_is_store_i;
              baddr_d = x_addr_i;
              be_d    = be_n;
              wdata_d = wd_n;
            end
          end
        end
        REQ: begin
          cnt_d = cnt_q + 1'b1;
          if (dm_gnt_i) state_d = RESP;
        end
        RESP: begin
          cnt_d = cnt_q + 1'b1;
          if (dm_rvalid_i) begin
            state_d = IDLE;
            blk_d   = 1'b1;
            if (we_q) begin
              st_done_d = 1'b1;
            end else begin
              ld_done_d = 1'b1;
              dout_d    = dm_rdata_i;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      blk_q     <= 1'b0;
      we_q      <= 1'b0;
      baddr_q   <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
      exc_q     <= '0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      mis_q     <= 1'b0;
      flt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blk_q     <= blk_d;
      we_q      <= we_d;
      baddr_q   <= baddr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
      exc_q     <= exc_d;
      ld_done_q <= ld_done_d;
      st_done_q <= st_done_d;
      mis_q     <= mis_d;
      flt_q     <= flt_d;
    end
  end

  assign stall_o          = (state_q != IDLE);
  assign dm_req_o         = (state_q == REQ);
  assign dm_we_o          = we_q;
  assign dm_addr_o        = {baddr_q[31:2], 2'b00};
  assign dm_be_o          = be_q;
  assign dm_wdata_o       = wdata_q;
  assign m_dm_dout_o      = dout_q;
  assign m_load_done_o    = ld_done_q;
  assign m_store_done_o   = st_done_q;
  assign m_misalign_o     = mis_q;
  assign m_access_fault_o = flt_q;
  assign m_exc_addr_o     = exc_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed cases plus random
// loads/stores against a byte-lane reference model.
module tb_lsu_mem_stage;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        x_valid_i = 1'b0;
  logic        x_is_load_i = 1'b0;
  logic        x_is_store_i = 1'b0;
  logic [2:0]  x_funct3_i = '0;
  logic [31:0] x_addr_i = '0;
  logic [31:0] x_store_data_i = '0;
  logic        stall_o;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_wdata_o;
  logic        dm_gnt_i = 1'b0;
  logic        dm_rvalid_i = 1'b0;
  logic [31:0] dm_rdata_i = '0;
  logic [31:0] m_dm_dout_o;
  logic        m_load_done_o;
  logic        m_store_done_o;
  logic        m_misalign_o;
  logic        m_access_fault_o;
  logic [31:0] m_exc_addr_o;

  lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .x_valid_i(x_valid_i), .x_is_load_i(x_is_load_i),
    .x_is_store_i(x_is_store_i), .x_funct3_i(x_funct3_i),
    .x_addr_i(x_addr_i), .x_store_data_i(x_store_data_i),
    .stall_o(stall_o), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o),
    .dm_addr_o(dm_addr_o), .dm_be_o(dm_be_o), .dm_wdata_o(dm_wdata_o),
    .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i),
    .dm_rdata_i(dm_rdata_i), .m_dm_dout_o(m_dm_dout_o),
    .m_load_done_o(m_load_done_o), .m_store_done_o(m_store_done_o),
    .m_misalign_o(m_misalign_o), .m_access_fault_o(m_access_fault_o),
    .m_exc_addr_o(m_exc_addr_o)
  );

  always #5 clk = ~clk;

  // kind: 0 load done, 1 store done, 2 misalign, 3 access fault
  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_dout = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every result pulse must match the head of the scoreboard
  initial begin
    int n;
    int kind;
    exp_t e;
    forever begin
      @(negedge clk);
      n = int'(m_load_done_o) + int'(m_store_done_o)
        + int'(m_misalign_o) + int'(m_access_fault_o);
      if (n > 1) begin
        chk("single_pulse", n, 1);
      end else if (n == 1) begin
        kind = m_load_done_o ? 0 : m_store_done_o ? 1 :
               m_misalign_o ? 2 : 3;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", kind, e.kind);
          if (e.kind == 0) exp_dout = e.val;
          if (e.kind >= 2) chk("exc_addr", m_exc_addr_o, e.val);
        end
      end
      chk("dout_held", m_dm_dout_o, exp_dout);
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_ctl"},
        {27'd0, stall_o, dm_req_o, dm_we_o, m_load_done_o,
         m_store_done_o} | {28'd0, dm_be_o}, 0);
    chk({tag, "_flags"}, {30'd0, m_misalign_o, m_access_fault_o}, 0);
    chk({tag, "_addr"}, dm_addr_o, 0);
    chk({tag, "_wdata"}, dm_wdata_o, 0);
    chk({tag, "_dout"}, m_dm_dout_o, 0);
    chk({tag, "_exc"}, m_exc_addr_o, 0);
  endtask

  // One op, starting #1 after a rising edge with the DUT idle.
  // g: REQ cycles before gnt, r: RESP cycles before rvalid.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input int g, input int r, input logic [31:0] rd);
    int          bytes;
    bit          legal;
    bit          bad;
    bit          ok;
    int          off;
    int          fin;
    int          lim;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    bytes = 1 << f3[1:0];
    legal = (ld != st) &&
            (ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                : (f3 inside {3'd0, 3'd1, 3'd2}));
    off = int'(a[1:0]);
    fin = g + r + 2;
    ok  = fin < TO;
    bad = 1'b1;
    if (!legal) sb.push_back('{3, a});
    else if (off % bytes != 0) sb.push_back('{2, a});
    else begin
      bad = 1'b0;
      if (!ok) sb.push_back('{3, a});
      else if (ld) sb.push_back('{0, rd});
      else sb.push_back('{1, 32'd0});
    end
    ebe = '0;
    ewd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + bytes) ebe[i] = 1'b1;
      if (st) ewd[8*i +: 8] = d[8*(i % bytes) +: 8];
    end
    x_valid_i = 1'b1;
    x_is_load_i = ld;
    x_is_store_i = st;
    x_funct3_i = f3;
    x_addr_i = a;
    x_store_data_i = d;
    @(posedge clk); #1;
    x_valid_i = 1'b0;
    if (bad) begin
      chk("bad_no_req", {31'd0, dm_req_o}, 0);
      chk("bad_no_stall", {31'd0, stall_o}, 0);
      @(posedge clk); #1;
      return;
    end
    lim = ((fin > TO) ? fin : TO) + 1;
    for (int k = 1; k <= lim; k++) begin
      chk("req", {31'd0, dm_req_o}, {31'd0, k <= ((g + 1 < TO) ? g + 1 : TO)});
      chk("stall", {31'd0, stall_o}, {31'd0, k <= ((fin < TO) ? fin : TO)});
      chk("done_pulse", {31'd0, m_load_done_o | m_store_done_o},
          {31'd0, ok && k == fin + 1});
      chk("tmo_pulse", {31'd0, m_access_fault_o},
          {31'd0, !ok && k == TO + 1});
      if (dm_req_o) begin
        chk("dm_addr", dm_addr_o, {a[31:2], 2'b00});
        chk("dm_be", {28'd0, dm_be_o}, {28'd0, ebe});
        chk("dm_we", {31'd0, dm_we_o}, {31'd0, st});
        chk("dm_wdata", dm_wdata_o, ewd);
      end
      dm_gnt_i = (k == g + 1);
      dm_rvalid_i = (k == fin) || (k <= g && $urandom_range(1) == 1);
      dm_rdata_i = (k == fin) ? rd : $urandom;
      @(posedge clk); #1;
    end
    dm_gnt_i = 1'b0;
    dm_rvalid_i = 1'b0;
  endtask

  initial begin
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk_zero("reset");

    do_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    do_op(0, 1, 3'b000, 32'h203, 32'hA5, 3, 0, 32'h0);
    do_op(1, 0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0);
    do_op(1, 0, 3'b011, 32'h104, 32'h0, 0, 0, 32'h0);
    do_op(1, 1, 3'b010, 32'h108, 32'h0, 0, 0, 32'h0);
    do_op(0, 1, 3'b001, 32'h10E, 32'h1234ABCD, 1, 1, 32'h0);
    do_op(1, 0, 3'b100, 32'h10B, 32'h0, 0, 2, 32'h11223344);
    do_op(1, 0, 3'b010, 32'h200, 32'h0, TO + 2, 0, 32'hCAFEF00D);

    // reset while waiting for the response
    x_valid_i = 1'b1;
    x_is_load_i = 1'b1;
    x_is_store_i = 1'b0;
    x_funct3_i = 3'b010;
    x_addr_i = 32'h40;
    @(posedge clk); #1;
    x_valid_i = 1'b0;
    dm_gnt_i = 1'b1;
    @(posedge clk); #1;
    dm_gnt_i = 1'b0;
    chk("resp_stall", {31'd0, stall_o}, 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_dout = '0;
    chk_zero("mid_reset");
    dm_rvalid_i = 1'b1;
    dm_rdata_i = 32'h55AA55AA;
    @(posedge clk); #1;
    dm_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int n = 0; n < 250; n++) begin
      ld = $urandom_range(1) == 1;
      st = !ld;
      if ($urandom_range(15) == 0) begin
        ld = 1'b1;
        st = 1'b1;
      end
      if ($urandom_range(3) == 0) f3 = 3'($urandom_range(7));
      else if (ld) f3 = 3'($urandom_range(4)) == 3 ? 3'd5 :
                        3'($urandom_range(2));
      else f3 = 3'($urandom_range(2));
      if (f3 == 3'd4 && $urandom_range(1) == 1) f3 = 3'd4;
      a = $urandom;
      if ($urandom_range(1) == 1) a[1:0] = a[1:0] & ~2'(((1 << f3[1:0]) - 1));
      do_op(ld, st, f3, a, $urandom, $urandom_range(4),
            $urandom_range(3), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
